// File: rtl/rtl_bigreg_writer.sv
// Publishes one wide value as consecutive mem-map words, bracketed by a
// valid entry that is cleared first and set last so the PS never reads a torn value.
module rtl_bigreg_writer #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DATA_WIDTH = 16,
  parameter int MEM_SIZE       = 256,
  parameter int BASE_ID        = 27,
  parameter int WAIT_FOR_ACK   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic [$clog2(MEM_SIZE)-1:0] wr_id,
  output logic [MEM_DATA_WIDTH-1:0]   wr_data,
  output logic                        wr_valid,
  input  logic                        wr_ready,
  input  logic                        ps_ack,
  output logic                        busy
);

  localparam int SAMPLES  = DATA_WIDTH / MEM_DATA_WIDTH;
  localparam int ID_W     = $clog2(MEM_SIZE);
  localparam int VALID_ID = BASE_ID + SAMPLES;
  localparam int CNT_W    = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  localparam logic [ID_W-1:0]  BASE_IDX  = ID_W'(BASE_ID);
  localparam logic [ID_W-1:0]  VALID_IDX = ID_W'(VALID_ID);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SAMPLES - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CLR_VALID  = 3'd1;
  localparam logic [2:0] S_WRITE_WORD = 3'd2;
  localparam logic [2:0] S_SET_VALID  = 3'd3;
  localparam logic [2:0] S_WAIT_ACK   = 3'd4;

  generate
    if ((SAMPLES < 1) || (DATA_WIDTH % MEM_DATA_WIDTH != 0)) begin : g_bad_width
      $error("rtl_bigreg_writer: DATA_WIDTH must be a non-zero multiple of MEM_DATA_WIDTH");
    end
    if (VALID_ID >= MEM_SIZE) begin : g_bad_id
      $error("rtl_bigreg_writer: BASE_ID + SAMPLES must be below MEM_SIZE");
    end
  endgenerate

  logic [2:0]                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     shadow_q, shadow_d;
  logic                      wr_valid_q, wr_valid_d;
  logic [ID_W-1:0]           wr_id_q, wr_id_d;
  logic [MEM_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                      ready_en_q, ready_en_d;

  logic                      capture;
  logic                      wr_xfer;
  logic [CNT_W-1:0]          cnt_inc;
  logic [MEM_DATA_WIDTH-1:0] shadow_words [SAMPLES];

  // ready_en_q keeps data_in_ready low until the first edge after reset release
  assign data_in_ready = (state_q == S_IDLE) && ready_en_q;
  assign capture       = data_in_valid && data_in_ready;
  assign wr_xfer       = wr_valid_q && wr_ready;
  assign cnt_inc       = cnt_q + CNT_W'(1);

  assign wr_valid = wr_valid_q;
  assign wr_id    = wr_id_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    for (int i = 0; i < SAMPLES; i++) begin
      shadow_words[i] = shadow_q[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
    end
  end

  // Outputs are registered, so each transition loads the next write request directly.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    wr_valid_d = wr_valid_q;
    wr_id_d    = wr_id_q;
    wr_data_d  = wr_data_q;
    ready_en_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (capture) begin
          shadow_d   = data_in;
          state_d    = S_CLR_VALID;
          wr_valid_d = 1'b1;
          wr_id_d    = VALID_IDX;
          wr_data_d  = '0;
        end
      end
      S_CLR_VALID: begin
        if (wr_xfer) begin
          state_d   = S_WRITE_WORD;
          cnt_d     = '0;
          wr_id_d   = BASE_IDX;
          wr_data_d = shadow_words[0];
        end
      end
      S_WRITE_WORD: begin
        if (wr_xfer) begin
          if (cnt_q == LAST_CNT) begin
            state_d   = S_SET_VALID;
            wr_id_d   = VALID_IDX;
            wr_data_d = MEM_DATA_WIDTH'(1);
          end else begin
            cnt_d     = cnt_inc;
            wr_id_d   = BASE_IDX + ID_W'(cnt_inc);
            wr_data_d = shadow_words[cnt_inc];
          end
        end
      end
      S_SET_VALID: begin
        if (wr_xfer) begin
          wr_valid_d = 1'b0;
          state_d    = (WAIT_FOR_ACK != 0) ? S_WAIT_ACK : S_IDLE;
        end
      end
      S_WAIT_ACK: begin
        if (ps_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        wr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shadow_q   <= '0;
      wr_valid_q <= 1'b0;
      wr_id_q    <= '0;
      wr_data_q  <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      wr_valid_q <= wr_valid_d;
      wr_id_q    <= wr_id_d;
      wr_data_q  <= wr_data_d;
      ready_en_q <= ready_en_d;
    end
  end

endmodule

// File: tb/tb_rtl_bigreg_writer.sv
// Bench for rtl_bigreg_writer: a queue-based publish model for the default
// instance, plus a constant-table check of a 48-bit no-ack instance.
module tb_rtl_bigreg_writer;

  localparam int DW   = 32;
  localparam int MW   = 16;
  localparam int BASE = 27;
  localparam int SAMP = DW / MW;
  localparam int VID  = BASE + SAMP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] data_in_a;
  logic        data_in_valid_a, data_in_ready_a;
  logic [7:0]  wr_id_a;
  logic [15:0] wr_data_a;
  logic        wr_valid_a, wr_ready_a, ps_ack_a, busy_a;

  logic [47:0] data_in_b;
  logic        data_in_valid_b, data_in_ready_b;
  logic [7:0]  wr_id_b;
  logic [15:0] wr_data_b;
  logic        wr_valid_b, wr_ready_b, ps_ack_b, busy_b;

  rtl_bigreg_writer dut_a (
    .clk(clk), .rst_n(rst_n),
    .data_in(data_in_a), .data_in_valid(data_in_valid_a), .data_in_ready(data_in_ready_a),
    .wr_id(wr_id_a), .wr_data(wr_data_a), .wr_valid(wr_valid_a), .wr_ready(wr_ready_a),
    .ps_ack(ps_ack_a), .busy(busy_a)
  );

  rtl_bigreg_writer #(.DATA_WIDTH(48), .BASE_ID(33), .WAIT_FOR_ACK(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .data_in(data_in_b), .data_in_valid(data_in_valid_b), .data_in_ready(data_in_ready_b),
    .wr_id(wr_id_b), .wr_data(wr_data_b), .wr_valid(wr_valid_b), .wr_ready(wr_ready_b),
    .ps_ack(ps_ack_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  // Model of instance A: pending writes still owed, ack wait flag, held outputs.
  logic [23:0] expQ[$];
  logic [23:0] xferLog[$];
  logic        waitAck  = 1'b0;
  logic        released = 1'b0;
  logic [7:0]  lastId   = 8'd0;
  logic [15:0] lastData = 16'd0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic publish(input logic [31:0] d);
    expQ.push_back({8'(VID), 16'h0000});
    for (int i = 0; i < SAMP; i++) begin
      expQ.push_back({8'(BASE + i), d[i*MW +: MW]});
    end
    expQ.push_back({8'(VID), 16'h0001});
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic rdy, input logic ack);
    logic        modelReady;
    logic [23:0] head;
    @(posedge clk);
    #1;
    data_in_valid_a = v;
    data_in_a       = d;
    wr_ready_a      = rdy;
    ps_ack_a        = ack;
    @(negedge clk);
    modelReady = (expQ.size() == 0) && !waitAck && released;
    checkOutput("data_in_ready", 64'(data_in_ready_a), 64'(modelReady));
    checkOutput("busy", 64'(busy_a), 64'((expQ.size() != 0) || waitAck));
    checkOutput("wr_valid", 64'(wr_valid_a), 64'(expQ.size() != 0));
    if (expQ.size() != 0) begin
      head = expQ[0];
      checkOutput("wr_id", 64'(wr_id_a), 64'(head[23:16]));
      checkOutput("wr_data", 64'(wr_data_a), 64'(head[15:0]));
    end else begin
      checkOutput("hold_wr_id", 64'(wr_id_a), 64'(lastId));
      checkOutput("hold_wr_data", 64'(wr_data_a), 64'(lastData));
    end
    released = 1'b1;
    if (expQ.size() != 0) begin
      if (rdy) begin
        xferLog.push_back({wr_id_a, wr_data_a});
        head     = expQ.pop_front();
        lastId   = head[23:16];
        lastData = head[15:0];
        if (expQ.size() == 0) waitAck = 1'b1;
      end
    end else if (waitAck) begin
      if (ack) waitAck = 1'b0;
    end else if (modelReady && v) begin
      publish(d);
    end
  endtask

  task automatic checkLog(input string tag, input logic [31:0] d);
    logic [23:0] want [4];
    logic [23:0] got;
    want[0] = {8'd29, 16'h0000};
    want[1] = {8'd27, d[15:0]};
    want[2] = {8'd28, d[31:16]};
    want[3] = {8'd29, 16'h0001};
    checkOutput({tag, "_count"}, 64'(xferLog.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      got = (xferLog.size() > i) ? xferLog[i] : 24'hxxxxxx;
      checkOutput($sformatf("%s_%0d", tag, i), 64'(got), 64'(want[i]));
    end
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_before_first_edge", 64'(data_in_ready_a), 64'd0);
    released = 1'b1;
  endtask

  task automatic assertReset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    data_in_valid_a = 1'b0;
    #1;
    checkOutput("rst_wr_valid", 64'(wr_valid_a), 64'd0);
    checkOutput("rst_busy", 64'(busy_a), 64'd0);
    checkOutput("rst_ready", 64'(data_in_ready_a), 64'd0);
    checkOutput("rst_wr_id", 64'(wr_id_a), 64'd0);
    checkOutput("rst_wr_data", 64'(wr_data_a), 64'd0);
    expQ.delete();
    waitAck  = 1'b0;
    released = 1'b0;
    lastId   = 8'd0;
    lastData = 16'd0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic        found;
    logic [23:0] tail;
    logic [31:0] val;
    logic [7:0]  idsB [5];
    logic [15:0] datB [5];
    int          ph;

    data_in_a = '0; data_in_valid_a = 1'b0; wr_ready_a = 1'b1; ps_ack_a = 1'b0;
    data_in_b = '0; data_in_valid_b = 1'b0; wr_ready_b = 1'b1; ps_ack_b = 1'b0;

    #3;
    checkOutput("init_wr_valid", 64'(wr_valid_a), 64'd0);
    checkOutput("init_ready", 64'(data_in_ready_a), 64'd0);
    checkOutput("init_busy", 64'(busy_a), 64'd0);
    checkOutput("init_wr_id", 64'(wr_id_a), 64'd0);
    repeat (2) @(posedge clk);
    releaseReset();

    // basic publish then wait for ack
    xferLog.delete();
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkLog("basic", 32'hDEADBEEF);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    // backpressure while word 28 is offered
    xferLog.delete();
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkLog("backpressure", 32'hDEADBEEF);

    // new data held during ack wait; ack coincident with final transfer is ignored
    repeat (4) applyStimulus(1'b1, 32'h12345678, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h12345678, 1'b1, 1'b1);
    xferLog.delete();
    applyStimulus(1'b1, 32'h12345678, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkLog("ackgate", 32'h12345678);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    // stray acks and data changing mid-sequence
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    xferLog.delete();
    applyStimulus(1'b1, 32'hA5A55A5A, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0BADF00D, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hFFFF0000, 1'b1, 1'b1);
    applyStimulus(1'b0, $urandom, 1'b1, 1'b0);
    applyStimulus(1'b0, $urandom, 1'b1, 1'b0);
    checkLog("stray", 32'hA5A55A5A);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    // reset right after the first data word transfer
    xferLog.delete();
    val = $urandom;
    applyStimulus(1'b1, val, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(1'b0, $urandom, 1'b1, 1'b0);
      if (xferLog.size() > 0) begin
        tail = xferLog[xferLog.size()-1];
        if (tail[23:16] == 8'd27) found = 1'b1;
      end
    end
    checkOutput("reached_word27", 64'(found), 64'd1);
    assertReset();
    releaseReset();
    xferLog.delete();
    val = $urandom;
    applyStimulus(1'b1, val, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkLog("after_reset", val);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(1)), $urandom, ($urandom_range(3) != 0), ($urandom_range(4) == 0));
    end

    // 48-bit instance without ack: back-to-back publishes, one idle cycle apart
    idsB[0] = 8'd36; idsB[1] = 8'd33; idsB[2] = 8'd34; idsB[3] = 8'd35; idsB[4] = 8'd36;
    datB[0] = 16'h0000; datB[1] = 16'hCCCC; datB[2] = 16'hBBBB; datB[3] = 16'hAAAA; datB[4] = 16'h0001;
    @(posedge clk);
    #1;
    data_in_valid_b = 1'b1;
    data_in_b       = 48'hAAAA_BBBB_CCCC;
    wr_ready_b      = 1'b1;
    @(negedge clk);
    checkOutput("b_ready_idle", 64'(data_in_ready_b), 64'd1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      ph = k % 6;
      checkOutput($sformatf("b_wr_valid_%0d", k), 64'(wr_valid_b), 64'(ph != 0));
      checkOutput($sformatf("b_busy_%0d", k), 64'(busy_b), 64'(ph != 0));
      checkOutput($sformatf("b_ready_%0d", k), 64'(data_in_ready_b), 64'(ph == 0));
      if (ph != 0) begin
        checkOutput($sformatf("b_wr_id_%0d", k), 64'(wr_id_b), 64'(idsB[ph-1]));
        checkOutput($sformatf("b_wr_data_%0d", k), 64'(wr_data_b), 64'(datB[ph-1]));
      end
    end
    data_in_valid_b = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtl_bigreg_writer.md
Name: rtl_bigreg_writer

Overview:
Serializes one wide RTL-produced value (e.g. the 32-bit buffer timestamp) into consecutive 16-bit mem-map entries for the PS to read. The entries are BASE_ID .. BASE_ID+SAMPLES-1, followed by a valid entry at BASE_ID+SAMPLES. It is the RTL_BIGREG counterpart of the PS_BIGREG reassembly path. It sits between an RTL producer (e.g. buffer timestamp logic) and the mem-map RTL write port.
- Write ordering: invalidate, then data words, then set valid. The PS never sees a torn value while valid=1.

Parameters:
- DATA_WIDTH, 32: width of the wide value. Must be a multiple of MEM_DATA_WIDTH.
- MEM_DATA_WIDTH, 16: data width of one mem-map entry.
- MEM_SIZE, 256: number of mem-map entries. The id width is $clog2(MEM_SIZE).
- BASE_ID, 27: first mem-map index. VALID_ID = BASE_ID+SAMPLES. Elaboration error if VALID_ID >= MEM_SIZE.
- WAIT_FOR_ACK, 1: if 1, block new captures until the PS consumes the value (ps_ack).
- Derived: SAMPLES = DATA_WIDTH/MEM_DATA_WIDTH.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- data_in, input, DATA_WIDTH: value to publish.
- data_in_valid, input, 1: producer offers data_in.
- data_in_ready, output, 1: block accepts data_in.
- wr_id, output, $clog2(MEM_SIZE): mem-map index of the current write.
- wr_data, output, MEM_DATA_WIDTH: data of the current write.
- wr_valid, output, 1: write request.
- wr_ready, input, 1: mem-map accepts the write.
- ps_ack, input, 1: 1-cycle pulse when the PS has read VALID_ID (fresh bit cleared).
- busy, output, 1: high whenever the FSM is not IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, wr_valid=0, wr_id=0, wr_data=0, busy=0, shadow register=0, word counter=0.
  - data_in_ready is forced 0 while rst_n=0.
  - data_in_ready=1 from the first clk edge after release.
- Input handshake:
  - Capture occurs when data_in_valid && data_in_ready at a rising edge. data_in is latched into the shadow register.
  - data_in_ready = (state==IDLE) && out of reset.
  - data_in is not sampled in any other state.
- Write handshake (AXI-style):
  - wr_valid, once high, stays high with wr_id/wr_data stable until a transfer (wr_valid && wr_ready).
  - wr_valid never drops without a transfer, except on reset.
- States:
  - IDLE: on capture -> CLR_VALID.
  - CLR_VALID: drive wr_id=VALID_ID, wr_data=0, wr_valid=1. On transfer -> WRITE_WORD, counter=0.
  - WRITE_WORD: drive wr_id=BASE_ID+counter, wr_data=shadow[counter*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] (LSW at BASE_ID).
    - On transfer with counter==SAMPLES-1 -> SET_VALID.
    - On transfer otherwise, counter+1.
  - SET_VALID: drive wr_id=VALID_ID, wr_data=1. On transfer -> WAIT_ACK if WAIT_FOR_ACK, else IDLE.
  - WAIT_ACK: wr_valid=0. ps_ack=1 -> IDLE.
- Timing:
  - With wr_ready tied high, capture at edge N gives wr_valid high cycles N+1 .. N+SAMPLES+2, i.e. SAMPLES+2 back-to-back transfers.
  - The final transfer is at edge N+SAMPLES+2.
  - data_in_ready returns high the cycle after the FSM re-enters IDLE.
- wr_id/wr_data are registered outputs. They hold their last driven value when wr_valid=0.
- ps_ack outside WAIT_ACK is ignored. This includes ps_ack coincident with the SET_VALID transfer: the FSM still enters WAIT_ACK.
- The shadow register is unchanged from capture until the next capture. Changes on data_in mid-sequence have no effect.
- Reset mid-sequence: the FSM aborts immediately and wr_valid drops. Any partially written entries remain in the mem-map.
  - If CLR_VALID had transferred, VALID_ID reads 0, so the PS sees no valid data.
- Width/index arithmetic is done at $clog2(MEM_SIZE) bits. There is no wrap, guaranteed by the elaboration check.

Test Plan:
- Basic publish: defaults, wr_ready=1, data_in=0xDEADBEEF.
  - Expect exactly 4 transfers on consecutive cycles: (29,0x0000), (27,0xBEEF), (28,0xDEAD), (29,0x0001).
  - Then busy=1 and data_in_ready=0 until ps_ack.
- Backpressure: wr_ready=0 for 3 cycles while wr_id=28.
  - Expect wr_valid=1 with wr_id=28 and wr_data=0xDEAD stable throughout.
  - Expect the sequence to complete with no duplicated or skipped entry.
- Ack gating: second data_in=0x12345678 held valid during WAIT_ACK.
  - Expect no capture until a ps_ack pulse.
  - Expect capture on the cycle after IDLE is re-entered, then (29,0),(27,0x5678),(28,0x1234),(29,1).
- Stray ack and data change: ps_ack pulsed in IDLE and WRITE_WORD; data_in changed mid-sequence.
  - Expect no state change from the ack.
  - Expect the written words to match the captured value.
- Reset mid-sequence: rst_n=0 right after the (27,…) transfer.
  - Expect wr_valid=0, busy=0 and data_in_ready=0 asynchronously.
  - After release: ready=1 and a fresh publish works.
- Parameter variant: DATA_WIDTH=48, BASE_ID=33, WAIT_FOR_ACK=0, data_in=0xAAAA_BBBB_CCCC.
  - Expect (36,0),(33,0xCCCC),(34,0xBBBB),(35,0xAAAA),(36,1).
  - Expect a return to IDLE with no ps_ack, so two back-to-back publishes are separated by exactly one idle cycle.
